// File: rtl/au_reservation_station_if.sv
// au_reservation_station_if: dispatch, CDB and issue signals of the AU reservation station
interface au_reservation_station_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    logic                         flush;
    logic                         dispatch_valid;
    logic                         dispatch_ready;
    logic [4:0]                   dispatch_execute_type;
    logic [TAG_W-1:0]             dispatch_rob_tag;
    logic                         dispatch_src1_ready;
    logic                         dispatch_src2_ready;
    logic [31:0]                  dispatch_src1_value;
    logic [31:0]                  dispatch_src2_value;
    logic [TAG_W-1:0]             dispatch_src1_tag;
    logic [TAG_W-1:0]             dispatch_src2_tag;
    logic                         cdb_valid;
    logic [TAG_W-1:0]             cdb_tag;
    logic [31:0]                  cdb_value;
    logic                         issue_valid;
    logic                         issue_ready;
    logic [31:0]                  operand1;
    logic [31:0]                  operand2;
    logic [4:0]                   execute_type;
    logic [TAG_W-1:0]             issue_rob_tag;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output flush, dispatch_valid, dispatch_execute_type, dispatch_rob_tag,
               dispatch_src1_ready, dispatch_src2_ready, dispatch_src1_value, dispatch_src2_value,
               dispatch_src1_tag, dispatch_src2_tag, cdb_valid, cdb_tag, cdb_value, issue_ready,
        input  dispatch_ready, issue_valid, operand1, operand2, execute_type, issue_rob_tag, count
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_execute_type, dispatch_rob_tag,
               dispatch_src1_ready, dispatch_src2_ready, dispatch_src1_value, dispatch_src2_value,
               dispatch_src1_tag, dispatch_src2_tag, cdb_valid, cdb_tag, cdb_value, issue_ready,
        output dispatch_ready, issue_valid, operand1, operand2, execute_type, issue_rob_tag, count
    );
endinterface

// File: rtl/au_reservation_station.sv
// au_reservation_station: compacting-queue reservation station feeding the AU, oldest-ready-first issue
module au_reservation_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    au_reservation_station_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic             v;
        logic [4:0]       et;
        logic [TAG_W-1:0] rt;
        logic             r1;
        logic             r2;
        logic [TAG_W-1:0] t1;
        logic [TAG_W-1:0] t2;
        logic [31:0]      d1;
        logic [31:0]      d2;
    } entry_t;

    entry_t          q  [DEPTH];
    entry_t          nq [DEPTH];
    entry_t          qx [DEPTH+1];
    entry_t          dent;
    logic [CW-1:0]   count;
    logic [CW-1:0]   widx;
    logic [IW-1:0]   sel;
    logic            ready_any;
    logic            fire;
    logic            disp;

    always_comb begin
        ready_any = 1'b0;
        sel       = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (q[i].v && q[i].r1 && q[i].r2) begin
                ready_any = 1'b1;
                sel       = IW'(i);
            end
    end

    assign fire               = ready_any && bus.issue_ready;
    assign disp               = bus.dispatch_valid && bus.dispatch_ready;
    assign widx               = count - CW'(fire);
    assign bus.dispatch_ready = count != CW'(DEPTH);
    assign bus.issue_valid    = ready_any;
    assign bus.operand1       = ready_any ? q[sel].d1 : '0;
    assign bus.operand2       = ready_any ? q[sel].d2 : '0;
    assign bus.execute_type   = ready_any ? q[sel].et : '0;
    assign bus.issue_rob_tag  = ready_any ? q[sel].rt : '0;
    assign bus.count          = count;

    // A source still waiting at dispatch can catch a result broadcast in the same cycle.
    always_comb begin
        dent    = '0;
        dent.v  = 1'b1;
        dent.et = bus.dispatch_execute_type;
        dent.rt = bus.dispatch_rob_tag;
        dent.t1 = bus.dispatch_src1_tag;
        dent.t2 = bus.dispatch_src2_tag;
        dent.r1 = bus.dispatch_src1_ready || (bus.cdb_valid && bus.dispatch_src1_tag == bus.cdb_tag);
        dent.r2 = bus.dispatch_src2_ready || (bus.cdb_valid && bus.dispatch_src2_tag == bus.cdb_tag);
        dent.d1 = bus.dispatch_src1_ready ? bus.dispatch_src1_value : bus.cdb_value;
        dent.d2 = bus.dispatch_src2_ready ? bus.dispatch_src2_value : bus.cdb_value;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) qx[i] = q[i];
        qx[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            nq[i] = (fire && IW'(i) >= sel) ? qx[i+1] : qx[i];
            if (bus.cdb_valid && nq[i].v && !nq[i].r1 && nq[i].t1 == bus.cdb_tag) begin
                nq[i].r1 = 1'b1;
                nq[i].d1 = bus.cdb_value;
            end
            if (bus.cdb_valid && nq[i].v && !nq[i].r2 && nq[i].t2 == bus.cdb_tag) begin
                nq[i].r2 = 1'b1;
                nq[i].d2 = bus.cdb_value;
            end
            if (disp && widx == CW'(i)) nq[i] = dent;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n || bus.flush) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count <= '0;
        end else begin
            q     <= nq;
            count <= count + CW'(disp) - CW'(fire);
        end
    end
endmodule

// File: tb/tb_au_reservation_station.sv
// tb_au_reservation_station: directed plus random stimulus checked against an age-ordered queue model
module tb_au_reservation_station;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    au_reservation_station_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();
    au_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [4:0]       et;
        logic [TAG_W-1:0] rt;
        logic             r1, r2;
        logic [TAG_W-1:0] t1, t2;
        logic [31:0]      d1, d2;
    } op_t;

    op_t mq[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ready_idx();
        foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
        return -1;
    endfunction

    task automatic idle();
        bus.dispatch_valid = 1'b0;
        bus.cdb_valid      = 1'b0;
        bus.flush          = 1'b0;
    endtask

    task automatic drv(logic [4:0] et, logic [TAG_W-1:0] rt,
                       logic r1, logic [31:0] d1, logic [TAG_W-1:0] t1,
                       logic r2, logic [31:0] d2, logic [TAG_W-1:0] t2);
        bus.dispatch_valid        = 1'b1;
        bus.dispatch_execute_type = et;
        bus.dispatch_rob_tag      = rt;
        bus.dispatch_src1_ready   = r1;
        bus.dispatch_src1_value   = d1;
        bus.dispatch_src1_tag     = t1;
        bus.dispatch_src2_ready   = r2;
        bus.dispatch_src2_value   = d2;
        bus.dispatch_src2_tag     = t2;
    endtask

    task automatic cdb(logic [TAG_W-1:0] t, logic [31:0] v);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = t;
        bus.cdb_value = v;
    endtask

    // Check outputs against the model, advance the model by the current inputs, then clock.
    task automatic cycle();
        int  k;
        bit  disp;
        op_t o;
        k = ready_idx();
        chk("issue_valid", 32'(bus.issue_valid), 32'(k >= 0));
        chk("operand1", bus.operand1, k >= 0 ? mq[k].d1 : 32'd0);
        chk("operand2", bus.operand2, k >= 0 ? mq[k].d2 : 32'd0);
        chk("execute_type", 32'(bus.execute_type), k >= 0 ? 32'(mq[k].et) : 32'd0);
        chk("issue_rob_tag", 32'(bus.issue_rob_tag), k >= 0 ? 32'(mq[k].rt) : 32'd0);
        chk("count", 32'(bus.count), 32'(mq.size()));
        chk("dispatch_ready", 32'(bus.dispatch_ready), 32'(mq.size() != DEPTH));
        if (rst_n || bus.flush) mq.delete();
        else begin
            disp = bus.dispatch_valid && mq.size() != DEPTH;
            if (k >= 0 && bus.issue_ready) mq.delete(k);
            if (bus.cdb_valid)
                foreach (mq[i]) begin
                    if (!mq[i].r1 && mq[i].t1 == bus.cdb_tag) begin mq[i].r1 = 1'b1; mq[i].d1 = bus.cdb_value; end
                    if (!mq[i].r2 && mq[i].t2 == bus.cdb_tag) begin mq[i].r2 = 1'b1; mq[i].d2 = bus.cdb_value; end
                end
            if (disp) begin
                o.et = bus.dispatch_execute_type;
                o.rt = bus.dispatch_rob_tag;
                o.t1 = bus.dispatch_src1_tag;
                o.t2 = bus.dispatch_src2_tag;
                o.r1 = bus.dispatch_src1_ready;
                o.r2 = bus.dispatch_src2_ready;
                o.d1 = bus.dispatch_src1_value;
                o.d2 = bus.dispatch_src2_value;
                if (!o.r1 && bus.cdb_valid && o.t1 == bus.cdb_tag) begin o.r1 = 1'b1; o.d1 = bus.cdb_value; end
                if (!o.r2 && bus.cdb_valid && o.t2 == bus.cdb_tag) begin o.r2 = 1'b1; o.d2 = bus.cdb_value; end
                mq.push_back(o);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        bus.issue_ready = 1'b0;
        bus.cdb_tag = '0;
        bus.cdb_value = '0;
        drv(5'd0, '0, 1'b0, 32'd0, '0, 1'b0, 32'd0, '0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        cycle();
        chk("reset_count", 32'(bus.count), 32'd0);
        chk("reset_issue_valid", 32'(bus.issue_valid), 32'd0);

        // Ready dispatch
        bus.issue_ready = 1'b1;
        drv(5'd1, 4'd3, 1'b1, 32'd7, 4'd0, 1'b1, 32'd9, 4'd0);
        cycle();
        idle();
        chk("ready_op1", bus.operand1, 32'd7);
        chk("ready_op2", bus.operand2, 32'd9);
        chk("ready_tag", 32'(bus.issue_rob_tag), 32'd3);
        cycle();
        chk("ready_count_after", 32'(bus.count), 32'd0);
        cycle();

        // Wakeup and ordering
        drv(5'd2, 4'd4, 1'b0, 32'd0, 4'd6, 1'b1, 32'd1, 4'd0);
        cycle();
        drv(5'd3, 4'd5, 1'b1, 32'd2, 4'd0, 1'b1, 32'd3, 4'd0);
        cycle();
        idle();
        chk("order_b_first", 32'(bus.issue_rob_tag), 32'd5);
        cycle();
        cdb(4'd6, 32'hDEAD);
        cycle();
        idle();
        chk("wake_op1", bus.operand1, 32'hDEAD);
        chk("wake_tag", 32'(bus.issue_rob_tag), 32'd4);
        cycle();
        cycle();

        // Bypass
        drv(5'd4, 4'd7, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd2);
        cdb(4'd2, 32'h55);
        cycle();
        idle();
        chk("bypass_op2", bus.operand2, 32'h55);
        cycle();
        cycle();

        // Full / backpressure
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv(5'(i + 8), 4'(i + 8), 1'b1, 32'(i), 4'd0, 1'b1, 32'(i + 100), 4'd0);
            cycle();
        end
        drv(5'd20, 4'd15, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_ready", 32'(bus.dispatch_ready), 32'd0);
        cycle();
        idle();
        bus.issue_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_tag", 32'(bus.issue_rob_tag), 32'(i + 8));
            cycle();
        end
        chk("drain_count", 32'(bus.count), 32'd0);
        cycle();

        // Flush with concurrent dispatch
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(5'd5, 4'(i), 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
            cycle();
        end
        drv(5'd6, 4'd9, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0);
        bus.flush = 1'b1;
        cycle();
        idle();
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_issue_valid", 32'(bus.issue_valid), 32'd0);
        bus.issue_ready = 1'b1;
        repeat (3) cycle();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) < 60)
                drv(5'($urandom), 4'($urandom), 1'($urandom), $urandom, 4'($urandom_range(0, 3)),
                    1'($urandom), $urandom, 4'($urandom_range(0, 3)));
            else bus.dispatch_valid = 1'b0;
            bus.cdb_valid   = 1'($urandom);
            bus.cdb_tag     = 4'($urandom_range(0, 3));
            bus.cdb_value   = $urandom;
            bus.issue_ready = $urandom_range(0, 99) < 65;
            bus.flush       = $urandom_range(0, 39) == 0;
            rst_n           = $urandom_range(0, 199) == 0;
            cycle();
        end
        rst_n = 1'b0;
        idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/au_reservation_station.md
# au_reservation_station

Reservation station directly upstream of the AU (arithmetic unit). It buffers dispatched AU micro-ops until both source operands are available, snoops the common data bus (CDB) to capture results produced elsewhere, and issues the oldest ready op to the AU as `operand1`/`operand2`/`execute_type`. It decouples in-order dispatch from out-of-order AU execution and is the only producer of AU inputs.

## Interface

Parameters:
- `DEPTH`, 4: number of entries (≥2).
- `TAG_W`, 4: ROB tag width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-high reset (1 = reset).
- `flush`  in  1  synchronous clear of all entries (mispredict recovery).
- `dispatch_valid`  in  1  dispatch offers an op.
- `dispatch_ready`  out  1  entry available; equals `count != DEPTH`.
- `dispatch_execute_type`  in  5  AU operation code.
- `dispatch_rob_tag`  in  TAG_W  destination ROB tag.
- `dispatch_src1_ready`, `dispatch_src2_ready`  in  1 each  source value is already valid.
- `dispatch_src1_value`, `dispatch_src2_value`  in  32 each  source value (used when ready).
- `dispatch_src1_tag`, `dispatch_src2_tag`  in  TAG_W each  producer tag (used when not ready).
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb_tag`  in  TAG_W  tag of the broadcast result.
- `cdb_value`  in  32  broadcast result.
- `issue_valid`  out  1  an entry is ready for the AU.
- `issue_ready`  in  1  AU accepts this cycle.
- `operand1`, `operand2`  out  32 each  issued source values.
- `execute_type`  out  5  issued op code.
- `issue_rob_tag`  out  TAG_W  issued op's ROB tag.
- `count`  out  $clog2(DEPTH+1)  occupied entries.

## Operation

- Entry fields: valid, execute_type, rob_tag, and per source: rdy, tag, value (32).
- Storage is a compacting queue: valid entries always occupy indices 0..count-1, with index 0 the oldest.
- Ready entry: valid && src1.rdy && src2.rdy.
- Issue select: the lowest-index ready entry. `issue_valid` = any ready entry. Outputs are driven combinationally from the selected entry; when `issue_valid`=0 they are 0.
- Issue handshake: the entry is removed at the edge where `issue_valid && issue_ready`. Entries above it shift down one index. At most one issue per cycle.
- Dispatch: accepted at the edge where `dispatch_valid && dispatch_ready`. It is written at index `count`, or at `count-1` if an issue happens in the same cycle.
- `dispatch_ready` depends only on registered `count`. A full station refuses dispatch even if it issues in the same cycle.
- CDB capture: at each edge with `cdb_valid`, every valid entry with a source where !rdy && tag==`cdb_tag` sets rdy=1 and value=`cdb_value`. The capture is applied to the post-shift position.
- CDB/dispatch bypass: if a dispatched source is not ready, `cdb_valid`=1, and its tag equals `cdb_tag` in the same cycle, the entry is written with rdy=1 and value=`cdb_value`.
- A source marked ready at dispatch ignores the CDB.
- `count` updates as +1 for dispatch, −1 for issue, unchanged for both or neither.
- `flush`=1: all entries are invalidated at that edge, `count`→0, and same-cycle dispatch and CDB capture are discarded. Same-cycle issue still presents outputs; the AU may latch them, and the ROB discards them by tag.
- `rst_n`=1: same effect as flush, with priority over everything. It is valid at any time, including mid-operation.

## Timing

- Reset values: `count`=0, `dispatch_ready`=1, `issue_valid`=0, `operand1`=`operand2`=0, `execute_type`=0, `issue_rob_tag`=0.
- Dispatch with both sources ready gives `issue_valid` in the next cycle (1-cycle minimum latency). There is no same-cycle dispatch-to-issue path.
- A CDB capture at edge N makes the entry issue-eligible in cycle N+1. No combinational CDB-to-issue path exists.
- `issue_ready`=0 holds the outputs stable. Selection may change only if an older entry becomes ready.
- Throughput: 1 dispatch and 1 issue per cycle sustained when not full.

## Test plan

- Reset/idle: hold `rst_n`=1 for 2 cycles, then release → `count`=0, `dispatch_ready`=1, `issue_valid`=0, all outputs 0.
- Ready dispatch: dispatch type 5'd1, srcs ready, values 32'd7/32'd9, tag 3, with `issue_ready`=1 → next cycle `issue_valid`=1, `operand1`=7, `operand2`=9, `issue_rob_tag`=3; the cycle after, `count`=0.
- Wakeup and ordering: dispatch A (src1 waits on tag 6), then B (both ready) → B issues first. Then CDB tag 6 value 32'hDEAD → A issues one cycle later with `operand1`=32'hDEAD.
- Bypass: dispatch with src2 not ready, tag 2, while `cdb_valid`=1, tag 2, value 32'h55 in the same cycle → next cycle issues with `operand2`=32'h55.
- Full/backpressure: `issue_ready`=0, dispatch 4 ready ops → `count`=4, `dispatch_ready`=0, a fifth dispatch is ignored. Then release `issue_ready` → the ops issue oldest-first across 4 consecutive cycles.
- Flush: with 3 entries held, assert `flush` together with a dispatch → next cycle `count`=0, `issue_valid`=0, and the dispatched op is never issued.
